// File: rtl/alu_seq.sv
// alu_seq: request-side sequencer for the combinational ALU.
// Accepts one operation per req handshake and holds registered operands and
// function code on the ALU for SETTLE_CYCLES edges. It then captures the
// qualified result and returns it through the rsp handshake. Illegal function
// codes and divide-by-zero are answered directly, without using the ALU.
// Optional feature: define ALU_SEQ_STICKY_FLAGS_EN to build flags_clr /
// flags_sticky, which accumulate every response's flags.
module alu_seq #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_func,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [5:0]  alu_func,
  input  logic [34:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_above,
  output logic        rsp_equals,
  output logic        rsp_overflow,
  output logic        rsp_illegal,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  input  logic        flags_clr,
  output logic [3:0]  flags_sticky,
`endif
  output logic        busy
);

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_DIV = 6'b011010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOT = 6'b100111;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  // Returns 1 for function codes the ALU implements.
  function automatic logic func_legal(input logic [5:0] f);
    logic ok;
    case (f)
      FN_ADD, FN_SUB, FN_MUL, FN_DIV, FN_AND, FN_OR, FN_NOT: ok = 1'b1;
      default:                                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [5:0]  func_q, func_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  // Flag order: {illegal, overflow, equals, above}.
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        load_rsp_s;
  logic        keep_cmp_s;
  logic        keep_ovf_s;

  // Flags from the ALU are only meaningful for some functions.
  assign keep_cmp_s = (func_q == FN_SUB);
  assign keep_ovf_s = (func_q == FN_ADD) || (func_q == FN_SUB) || (func_q == FN_MUL);

  // Next-state, operand load, counter and response-capture decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    func_d      = func_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    load_rsp_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!func_legal(req_func)) begin
            // Screened: the ALU never sees an illegal code.
            rsp_data_d  = 32'h0000_0000;
            rsp_flags_d = 4'b1000;
            load_rsp_s  = 1'b1;
            state_d     = ST_RESP;
          end else if ((req_func == FN_DIV) && (req_op2 == 32'h0000_0000)) begin
            // Screened: divide-by-zero is reported as overflow.
            rsp_data_d  = 32'h0000_0000;
            rsp_flags_d = 4'b0100;
            load_rsp_s  = 1'b1;
            state_d     = ST_RESP;
          end else begin
            op1_d   = req_op1;
            op2_d   = req_op2;
            func_d  = req_func;
            cnt_d   = CNT_INIT;
            state_d = ST_SETTLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = alu_result[31:0];
          rsp_flags_d = {1'b0,
                         alu_result[34] & keep_ovf_s,
                         alu_result[33] & keep_cmp_s,
                         alu_result[32] & keep_cmp_s};
          load_rsp_s  = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, ALU-side and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      op1_q       <= 32'h0000_0000;
      op2_q       <= 32'h0000_0000;
      func_q      <= 6'b000000;
      rsp_data_q  <= 32'h0000_0000;
      rsp_flags_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      func_q      <= func_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic [3:0] sticky_q;

  // Sticky flag accumulation; a coincident response load overrides a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 4'b0000;
    end else if (load_rsp_s) begin
      sticky_q <= flags_clr ? rsp_flags_d : (sticky_q | rsp_flags_d);
    end else if (flags_clr) begin
      sticky_q <= 4'b0000;
    end else begin
      sticky_q <= sticky_q;
    end
  end

  assign flags_sticky = sticky_q;
`endif

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_RESP);
  assign rsp_valid    = (state_q == ST_RESP);
  assign alu_op1      = op1_q;
  assign alu_op2      = op2_q;
  assign alu_func     = func_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_illegal  = rsp_flags_q[3];
  assign rsp_overflow = rsp_flags_q[2];
  assign rsp_equals   = rsp_flags_q[1];
  assign rsp_above    = rsp_flags_q[0];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized scoreboard bench for alu_seq with a behavioural ALU.
module tb_alu_seq;
  localparam int SETTLE = 3;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_DIV = 6'b011010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOT = 6'b100111;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_func;
  logic [31:0] req_op1, req_op2;
  logic [31:0] alu_op1, alu_op2;
  logic [5:0]  alu_func;
  logic [34:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_above, rsp_equals, rsp_overflow, rsp_illegal;
  logic        busy;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic        flags_clr;
  logic [3:0]  flags_sticky;
`endif

  logic [2:0]  junk;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic [31:0] m_op1 = 32'h0;
  logic [31:0] m_op2 = 32'h0;
  logic [5:0]  m_func = 6'h0;

  typedef struct {
    logic [35:0] rsp;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [5:0] legal_f [7];

  alu_seq #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_op1(req_op1), .req_op2(req_op2),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_above(rsp_above), .rsp_equals(rsp_equals),
    .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    .flags_clr(flags_clr), .flags_sticky(flags_sticky),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: flags it does not define are driven with junk bits.
  function automatic logic [34:0] alu_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [2:0] j);
    logic signed [31:0] sa, sbv;
    logic signed [63:0] p;
    logic [32:0] s;
    logic [31:0] d;
    logic ab, eq, ov;
    sa = a; sbv = b; ab = j[0]; eq = j[1]; ov = j[2]; d = 32'h0; s = 33'h0; p = 64'sh0;
    case (f)
      F_ADD: begin s = {a[31], a} + {b[31], b}; d = s[31:0]; ov = s[32] ^ s[31]; end
      F_SUB: begin
        s = {a[31], a} - {b[31], b}; d = s[31:0]; ov = s[32] ^ s[31];
        ab = (sa > sbv); eq = (a == b);
      end
      F_MUL: begin p = sa * sbv; d = p[31:0]; ov = (p[63:32] != {32{p[31]}}); end
      F_DIV: begin
        if (b == 32'h0) d = 32'h0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) d = a;
        else d = 32'(sa / sbv);
      end
      F_AND: d = a & b;
      F_OR:  d = a | b;
      F_NOT: d = ~a;
      default: d = 32'hDEAD_BEEF;
    endcase
    return {ov, eq, ab, d};
  endfunction

  assign alu_result = alu_model(alu_func, alu_op1, alu_op2, junk);

  function automatic bit is_legal(input logic [5:0] f);
    for (int i = 0; i < 7; i++) if (legal_f[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  // Expected response {illegal, overflow, equals, above, data} from the rules.
  function automatic logic [35:0] ref_rsp(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [2:0] j);
    logic [34:0] r;
    bit keep_cmp, keep_ov;
    if (!is_legal(f)) return {4'b1000, 32'h0};
    if (f == F_DIV && b == 32'h0) return {4'b0100, 32'h0};
    r = alu_model(f, a, b, j);
    keep_cmp = (f == F_SUB);
    keep_ov  = (f == F_ADD) || (f == F_SUB) || (f == F_MUL);
    return {1'b0, r[34] & keep_ov, r[33] & keep_cmp, r[32] & keep_cmp, r[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu", {alu_func, alu_op1, alu_op2}, 64'd0);
    chk("rst_rsp", 64'({rsp_illegal, rsp_overflow, rsp_equals, rsp_above, rsp_data}), 64'd0);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    chk("rst_sticky", 64'(flags_sticky), 64'd0);
`endif
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] j);
    exp_t e;
    int g;
    bit scr;
    g = 0;
    while (req_ready !== 1'b1 && g < 200) begin @(posedge clk); #1; g++; end
    chk("issue_wait_timeout", 64'(g < 200), 64'd1);
    junk = j; req_func = f; req_op1 = a; req_op2 = b; req_valid = 1'b1;
    scr = !is_legal(f) || (f == F_DIV && b == 32'h0);
    e.rsp = ref_rsp(f, a, b, j);
    @(posedge clk); #1;
    e.acc = cyc;
    e.lat = scr ? 0 : SETTLE;
    sb.push_back(e);
    req_valid = 1'b0;
    req_func = 6'($urandom); req_op1 = $urandom; req_op2 = $urandom;
    if (!scr) begin m_op1 = a; m_op2 = b; m_func = f; end
    chk("alu_op1", 64'(alu_op1), 64'(m_op1));
    chk("alu_op2", 64'(alu_op2), 64'(m_op2));
    chk("alu_func", 64'(alu_func), 64'(m_func));
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("req_ready_after_accept", 64'(req_ready), 64'd0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) && g < 500) begin
      @(posedge clk); #1; g++;
    end
    chk("wait_idle_timeout", 64'(g < 500), 64'd1);
  endtask

  // rsp_ready driver: random, forced low, or forced high.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each new response and checks it while held.
  initial begin
    exp_t cur;
    bit in_rsp, hs_prev;
    in_rsp = 1'b0; hs_prev = 1'b0;
    cur.rsp = 36'h0; cur.acc = 0; cur.lat = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_rsp = 1'b0; hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
          chk("post_hs_req_ready", 64'(req_ready), 64'd1);
        end
        if (rsp_valid) begin
          if (!in_rsp) begin
            in_rsp = 1'b1;
            chk("unexpected_rsp", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
              cur = sb.pop_front();
              chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
            end
          end
          chk("rsp_word", 64'({rsp_illegal, rsp_overflow, rsp_equals, rsp_above, rsp_data}),
              64'(cur.rsp));
          chk("req_ready_in_resp", 64'(req_ready), 64'd0);
          hs_prev = rsp_ready;
        end else begin
          in_rsp = 1'b0;
          hs_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    legal_f = '{F_ADD, F_SUB, F_MUL, F_DIV, F_AND, F_OR, F_NOT};
    reset = 1'b0; req_valid = 1'b0; req_func = 6'h0; req_op1 = 32'h0; req_op2 = 32'h0;
    junk = 3'b000;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif
    #1 reset = 1'b1;
    #2 check_reset_vals();
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the test plan.
    rdy_mode = 2;
    issue(F_ADD, 32'd5, 32'd7, 3'b111);
    issue(F_SUB, 32'd9, 32'd9, 3'b000);
    issue(F_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b111);
    issue(F_DIV, 32'd100, 32'd0, 3'b111);
    issue(6'b111111, 32'd1, 32'd2, 3'b111);
    wait_idle();

    // Back-pressure: hold rsp_ready low well past the response.
    rdy_mode = 1;
    issue(F_MUL, 32'd6, 32'd7, 3'b000);
    repeat (SETTLE + 10) @(posedge clk);
    #1 chk("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
    chk("bp_rsp_data_held", 64'(rsp_data), 64'd42);
    rdy_mode = 2;
    wait_idle();

    // Reset during SETTLE drops the pending response.
    issue(F_SUB, 32'd3, 32'd1, 3'b000);
    reset = 1'b1;
    void'(sb.pop_back());
    m_op1 = 32'h0; m_op2 = 32'h0; m_func = 6'h0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (SETTLE + 3) @(posedge clk);
    #1 chk("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
    issue(F_ADD, 32'd1, 32'd1, 3'b000);
    wait_idle();

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    issue(6'b111111, 32'd0, 32'd0, 3'b000);
    issue(F_SUB, 32'd2, 32'd1, 3'b000);
    wait_idle();
    chk("sticky_accum", 64'(flags_sticky), 64'h9);
    flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    chk("sticky_clr", 64'(flags_sticky), 64'h0);
    issue(6'b000000, 32'd0, 32'd0, 3'b000);
    wait_idle();
    chk("sticky_pre_coincide", 64'(flags_sticky), 64'h8);
    flags_clr = 1'b1;
    issue(F_DIV, 32'd5, 32'd0, 3'b000);
    flags_clr = 1'b0;
    chk("sticky_clr_vs_load", 64'(flags_sticky), 64'h4);
    wait_idle();
`endif

    // Randomized traffic with random back-pressure.
    rdy_mode = 0;
    for (int n = 0; n < 60; n++) begin
      logic [5:0] f;
      logic [31:0] a, b;
      f = ($urandom_range(0, 9) < 8) ? legal_f[$urandom_range(0, 6)] : 6'($urandom);
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      b = ($urandom_range(0, 4) == 0) ? 32'h0 :
          (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)));
      if ($urandom_range(0, 3) == 0) a = b;
      issue(f, a, b, 3'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 2;
    wait_idle();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
